// File: rtl/lzx_nibble_sub.sv
// lzx_nibble_sub: multi-cycle two's-complement subtractor, D = A - B - Bin.
//
// One 4-bit nibble is processed per clock through a single 283-style
// carry-lookahead slice fed with A and ~B. The carry into the first nibble
// is ~Bin. Results and flags are held until the next accepted start.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous, active-high reset
//   start - request; accepted in IDLE or DONE, ignored while busy
//   A, B  - minuend / subtrahend, sampled on the accepting edge
//   Bin   - borrow-in, sampled on the accepting edge
//   busy  - high while nibbles are being processed
//   done  - one-cycle pulse when D and flags become valid
//   D     - difference (modulo 2^WIDTH)
//   Bout  - borrow-out (1 = unsigned A < B + Bin)
//   ovf   - signed overflow
//   zero  - D == 0
//
// Optional build macro LZX_SUB_CMP_EN adds compare outputs lt_u and lt_s
// (unsigned / signed A < B + Bin), registered alongside the other flags.
module lzx_nibble_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf,
  output logic             zero
`ifdef LZX_SUB_CMP_EN
  ,
  output logic             lt_u,
  output logic             lt_s
`endif
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("lzx_nibble_sub: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 4-bit carry-lookahead slice; returns {c4, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic       ci);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1, c2, c3, c4;
    g  = a & b;
    p  = a ^ b;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c4, p ^ {c3, c2, c1, ci}};
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               c_q, c_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               ltu_q, ltu_d;
  logic               lts_q, lts_d;

  logic [4:0]         slice;
  logic [WIDTH-1:0]   d_upd;
  logic               last_nib;
  logic               accept;

  always_comb begin
    slice    = cla4(a_q[{idx_q, 2'b00} +: 4], ~b_q[{idx_q, 2'b00} +: 4], c_q);
    d_upd    = d_q;
    d_upd[{idx_q, 2'b00} +: 4] = slice[3:0];
    last_nib = (idx_q == IDX_W'(NIB - 1));
    accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    ltu_d   = ltu_q;
    lts_d   = lts_q;

    case (state_q)
      ST_RUN: begin
        d_d   = d_upd;
        c_d   = slice[4];
        idx_d = idx_q + IDX_W'(1);
        if (last_nib) begin
          // Flags use the fully assembled difference, including this nibble.
          bout_d  = ~slice[4];
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_upd[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (d_upd == '0);
          ltu_d   = ~slice[4];
          lts_d   = d_upd[WIDTH-1] ^ ((a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                      (d_upd[WIDTH-1] != a_q[WIDTH-1]));
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Acceptance overrides the IDLE/DONE defaults; D is left for RUN to overwrite.
    if (accept) begin
      a_d     = A;
      b_d     = B;
      c_d     = ~Bin;
      idx_d   = '0;
      bout_d  = 1'b0;
      ovf_d   = 1'b0;
      zero_d  = 1'b0;
      ltu_d   = 1'b0;
      lts_d   = 1'b0;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      ltu_q   <= 1'b0;
      lts_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      ltu_q   <= ltu_d;
      lts_q   <= lts_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign D    = d_q;
  assign Bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

`ifdef LZX_SUB_CMP_EN
  assign lt_u = ltu_q;
  assign lt_s = lts_q;
`else
  logic unused_cmp;
  assign unused_cmp = ltu_q ^ lts_q;
`endif

endmodule
